// File: rtl/tmp2_sampler.sv
// Periodic Pmod TMP2 acquisition: requests a read every PERIOD_CYCLES, normalises to 1/128 C, keeps avg/min/max/errors.
// Latency: sample/stats outputs update 2 cycles after the valid_i rising edge; timeout_o fires TIMEOUT_CYCLES after request.
// Backpressure: none; periodic ticks arriving while a request is in flight are dropped, not queued.
module tmp2_sampler #(
    parameter int PERIOD_CYCLES  = 100_000_000,
    parameter int TIMEOUT_CYCLES = 10_000_000,
    parameter int AVG_LOG2       = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        resolution,
    input  logic        clear_stats,
    output logic        update,
    input  logic        busy,
    input  logic        valid_i,
    input  logic [15:0] temperature_i,
    output logic [15:0] sample_o,
    output logic        sample_valid,
    output logic [15:0] average_o,
    output logic        average_valid,
    output logic [15:0] min_o,
    output logic [15:0] max_o,
    output logic        stats_valid,
    output logic        timeout_o,
    output logic [7:0]  err_count
);

    localparam int PW = (PERIOD_CYCLES > 2) ? $clog2(PERIOD_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int AW = 16 + AVG_LOG2;
    localparam int CW = AVG_LOG2 + 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_PROC} state_t;

    state_t state_q, state_d;

    logic [PW-1:0]        per_q, per_d;
    logic [TW-1:0]        to_q, to_d;
    logic                 valid_prev_q;
    logic [15:0]          raw_q, raw_d;
    logic signed [15:0]   sample_q, sample_d;
    logic                 sample_valid_q, sample_valid_d;
    logic signed [15:0]   average_q, average_d;
    logic                 average_valid_q, average_valid_d;
    logic signed [15:0]   min_q, min_d, max_q, max_d;
    logic                 stats_valid_q, stats_valid_d;
    logic                 timeout_q, timeout_d;
    logic [7:0]           err_q, err_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    logic                 tick;
    logic                 valid_edge;
    logic                 to_hit;
    logic                 timed_out;
    logic signed [15:0]   conv;
    logic signed [AW-1:0] acc_sum;
    logic signed [AW-1:0] avg_full;

    assign tick       = (per_q == '0) && enable;
    assign valid_edge = valid_i & ~valid_prev_q;
    assign to_hit     = (to_q == TW'(TIMEOUT_CYCLES - 1));
    assign timed_out  = ((state_q == S_REQ) || (state_q == S_WAIT)) && to_hit;

    // Period counter: reload on tick, otherwise count down and park at zero
    always_comb begin
        per_d = per_q;
        if (tick) begin
            per_d = PW'(PERIOD_CYCLES - 1);
        end else if (per_q != '0) begin
            per_d = per_q - PW'(1);
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; timeout takes priority over a same-cycle handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (tick) state_d = S_REQ;
            S_REQ:  if (to_hit) state_d = S_IDLE;
                    else if (busy) state_d = S_WAIT;
            S_WAIT: if (to_hit) state_d = S_IDLE;
                    else if (valid_edge) state_d = S_PROC;
            S_PROC: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: update is a pure state decode so reset drops it asynchronously
    always_comb begin
        update = (state_q == S_REQ);
    end

    // Request timer and raw-reading capture
    always_comb begin
        to_d  = to_q;
        raw_d = raw_q;
        if (state_q == S_IDLE) begin
            to_d = '0;
        end else if ((state_q == S_REQ) || (state_q == S_WAIT)) begin
            to_d = to_q + TW'(1);
        end
        if ((state_q == S_WAIT) && valid_edge && !to_hit) begin
            raw_d = temperature_i;
        end
    end

    // Conversion to 1/128 C: 13-bit mode drops the three status flag bits
    always_comb begin
        conv     = resolution ? raw_q : {raw_q[15:3], 3'b000};
        acc_sum  = acc_q + AW'(conv);
        avg_full = acc_sum >>> AVG_LOG2;
    end

    // Statistics, strobes and error counter; clear_stats overrides sample folding
    always_comb begin
        sample_d        = sample_q;
        sample_valid_d  = 1'b0;
        average_d       = average_q;
        average_valid_d = 1'b0;
        min_d           = min_q;
        max_d           = max_q;
        stats_valid_d   = stats_valid_q;
        timeout_d       = 1'b0;
        err_d           = err_q;
        acc_d           = acc_q;
        cnt_d           = cnt_q;
        if (state_q == S_PROC) begin
            sample_d       = conv;
            sample_valid_d = 1'b1;
            if (!stats_valid_q) begin
                min_d = conv;
                max_d = conv;
            end else begin
                if (conv < min_q) min_d = conv;
                if (conv > max_q) max_d = conv;
            end
            stats_valid_d = 1'b1;
            if (cnt_q == CW'((1 << AVG_LOG2) - 1)) begin
                average_d       = avg_full[15:0];
                average_valid_d = 1'b1;
                acc_d           = '0;
                cnt_d           = '0;
            end else begin
                acc_d = acc_sum;
                cnt_d = cnt_q + CW'(1);
            end
        end
        if (timed_out) begin
            timeout_d = 1'b1;
            if (err_q != 8'hFF) err_d = err_q + 8'd1;
        end
        if (clear_stats) begin
            average_valid_d = 1'b0;
            min_d           = '0;
            max_d           = '0;
            stats_valid_d   = 1'b0;
            err_d           = '0;
            acc_d           = '0;
            cnt_d           = '0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            per_q           <= '0;
            to_q            <= '0;
            valid_prev_q    <= 1'b0;
            raw_q           <= '0;
            sample_q        <= '0;
            sample_valid_q  <= 1'b0;
            average_q       <= '0;
            average_valid_q <= 1'b0;
            min_q           <= '0;
            max_q           <= '0;
            stats_valid_q   <= 1'b0;
            timeout_q       <= 1'b0;
            err_q           <= '0;
            acc_q           <= '0;
            cnt_q           <= '0;
        end else begin
            per_q           <= per_d;
            to_q            <= to_d;
            valid_prev_q    <= valid_i;
            raw_q           <= raw_d;
            sample_q        <= sample_d;
            sample_valid_q  <= sample_valid_d;
            average_q       <= average_d;
            average_valid_q <= average_valid_d;
            min_q           <= min_d;
            max_q           <= max_d;
            stats_valid_q   <= stats_valid_d;
            timeout_q       <= timeout_d;
            err_q           <= err_d;
            acc_q           <= acc_d;
            cnt_q           <= cnt_d;
        end
    end

    assign sample_o      = sample_q;
    assign sample_valid  = sample_valid_q;
    assign average_o     = average_q;
    assign average_valid = average_valid_q;
    assign min_o         = min_q;
    assign max_o         = max_q;
    assign stats_valid   = stats_valid_q;
    assign timeout_o     = timeout_q;
    assign err_count     = err_q;

endmodule

// File: tb/tb_tmp2_sampler.sv
// Scoreboard bench for tmp2_sampler: a responder plays the TMP2 interface, a model predicts each output event.
// Expected responses are queued at stimulus time and popped by an independent negedge monitor.
// Fixed small parameters keep timeouts and averaging blocks short.
module tb_tmp2_sampler;

    localparam int PER = 20;
    localparam int TO  = 50;
    localparam int AL  = 2;

    logic        clk = 1'b0;
    logic        rst, enable, resolution, clear_stats, busy, valid_i;
    logic [15:0] temperature_i;
    logic        update, sample_valid, average_valid, stats_valid, timeout_o;
    logic [15:0] sample_o, average_o, min_o, max_o;
    logic [7:0]  err_count;

    tmp2_sampler #(.PERIOD_CYCLES(PER), .TIMEOUT_CYCLES(TO), .AVG_LOG2(AL)) dut (
        .clk(clk), .rst(rst), .enable(enable), .resolution(resolution),
        .clear_stats(clear_stats), .update(update), .busy(busy), .valid_i(valid_i),
        .temperature_i(temperature_i), .sample_o(sample_o), .sample_valid(sample_valid),
        .average_o(average_o), .average_valid(average_valid), .min_o(min_o), .max_o(max_o),
        .stats_valid(stats_valid), .timeout_o(timeout_o), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sample; int mn; int mx; int sv; int av; int avg; int err;
    } exp_t;

    exp_t exp_q[$];
    int   to_exp_q[$];
    int   hist[$];
    int   blk[$];
    int   err_m    = 0;
    int   checks   = 0;
    int   errors   = 0;
    int   rises    = 0;
    int   requests = 0;
    int   run      = 0;
    int   last_run = 0;
    logic upd_prev = 1'b0;

    task automatic check(string name, int act, int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Raw register to signed 1/128 C; 13-bit mode rounds down to a multiple of 8
    function automatic int to_celsius128(logic [15:0] raw, bit res);
        int s;
        s = int'($signed(raw));
        if (!res) s = s - (((s % 8) + 8) % 8);
        return s;
    endfunction

    function automatic int floor_div(int num, int den);
        if (num >= 0) return num / den;
        return -((-num + den - 1) / den);
    endfunction

    task automatic model_clear();
        hist.delete();
        blk.delete();
        err_m = 0;
    endtask

    task automatic model_sample(int s, bit clr);
        exp_t e;
        int sum;
        e.sample = s; e.av = 0; e.avg = 0;
        if (clr) begin
            model_clear();
            e.sv = 0; e.mn = 0; e.mx = 0;
        end else begin
            hist.push_back(s);
            blk.push_back(s);
            e.mn = hist[0]; e.mx = hist[0];
            foreach (hist[i]) begin
                if (hist[i] < e.mn) e.mn = hist[i];
                if (hist[i] > e.mx) e.mx = hist[i];
            end
            e.sv = 1;
            if (blk.size() == (1 << AL)) begin
                sum = 0;
                foreach (blk[i]) sum += blk[i];
                e.avg = floor_div(sum, 1 << AL);
                e.av  = 1;
                blk.delete();
            end
        end
        e.err = err_m;
        exp_q.push_back(e);
    endtask

    // Monitor: counts requests, measures update width, pops expectations on strobes
    initial begin
        exp_t e;
        int   te;
        forever begin
            @(negedge clk);
            if (update && !upd_prev) rises++;
            if (update) run++;
            else if (upd_prev) begin
                last_run = run;
                run = 0;
            end
            upd_prev = update;
            if (sample_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_sample_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("sample_o", int'($signed(sample_o)), e.sample);
                    check("min_o", int'($signed(min_o)), e.mn);
                    check("max_o", int'($signed(max_o)), e.mx);
                    check("stats_valid", int'(stats_valid), e.sv);
                    check("average_valid", int'(average_valid), e.av);
                    if (e.av != 0) check("average_o", int'($signed(average_o)), e.avg);
                    check("err_count_at_sample", int'(err_count), e.err);
                end
            end else if (average_valid) begin
                check("average_valid_without_sample", 1, 0);
            end
            if (timeout_o) begin
                if (to_exp_q.size() == 0) begin
                    check("unexpected_timeout", 1, 0);
                end else begin
                    te = to_exp_q.pop_front();
                    check("err_count_at_timeout", int'(err_count), te);
                    check("update_width_before_timeout", last_run, TO);
                end
            end
        end
    end

    task automatic wait_request(output bit got);
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(posedge clk); #1;
            if (update) got = 1'b1;
        end
        check("request_seen", int'(got), 1);
    endtask

    // Play one TMP2 read: busy after bd cycles, hold busy, then valid edge with the reading
    task automatic serve(bit res, logic [15:0] raw, int bd, int hold, int vd, bit clr, bit rst_mid);
        bit got;
        bit upd_bad;
        upd_bad = 1'b0;
        resolution = res;
        wait_request(got);
        if (!got) return;
        requests++;
        repeat (bd) @(posedge clk);
        #1;
        busy = 1'b1; valid_i = 1'b0;
        repeat (hold) begin
            @(posedge clk); #1;
            if (update) upd_bad = 1'b1;
        end
        check("no_update_in_wait", int'(upd_bad), 0);
        busy = 1'b0;
        if (rst_mid) begin
            rst = 1'b1;
            #1;
            check("rst_update", int'(update), 0);
            check("rst_sample_o", int'(sample_o), 0);
            check("rst_min_o", int'(min_o), 0);
            check("rst_max_o", int'(max_o), 0);
            check("rst_average_o", int'(average_o), 0);
            check("rst_stats_valid", int'(stats_valid), 0);
            check("rst_err_count", int'(err_count), 0);
            check("rst_strobes", int'({sample_valid, average_valid, timeout_o}), 0);
            model_clear();
            @(posedge clk); @(posedge clk); #1;
            rst = 1'b0;
            return;
        end
        repeat (vd) @(posedge clk);
        #1;
        temperature_i = raw; valid_i = 1'b1;
        model_sample(to_celsius128(raw, res), clr);
        if (clr) begin
            @(posedge clk); #1; clear_stats = 1'b1;
            @(posedge clk); #1; clear_stats = 1'b0;
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic do_timeout();
        bit got;
        wait_request(got);
        if (!got) return;
        requests++;
        err_m = (err_m == 255) ? 255 : err_m + 1;
        to_exp_q.push_back(err_m);
        got = 1'b0;
        for (int i = 0; i < TO + 10 && !got; i++) begin
            @(posedge clk); #1;
            if (!update) got = 1'b1;
        end
        check("timeout_releases_update", int'(got), 1);
        @(posedge clk); #1;
    endtask

    task automatic pulse_clear();
        clear_stats = 1'b1;
        @(posedge clk); #1;
        clear_stats = 1'b0;
        model_clear();
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; enable = 1'b0; resolution = 1'b1; clear_stats = 1'b0;
        busy = 1'b0; valid_i = 1'b0; temperature_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_update", int'(update), 0);
        check("reset_outputs", int'(|{sample_o, average_o, min_o, max_o, err_count}), 0);
        check("reset_flags", int'({sample_valid, average_valid, stats_valid, timeout_o}), 0);
        rst = 1'b0;
        enable = 1'b1;

        // 16-bit format then 13-bit negative with status flags
        serve(1'b1, 16'h0C80, 3, 2, 1, 1'b0, 1'b0);
        serve(1'b0, 16'hFF07, 3, 2, 1, 1'b0, 1'b0);

        // Averaging blocks, one positive and one negative with floor rounding
        pulse_clear();
        serve(1'b1, 16'd100, 2, 1, 1, 1'b0, 1'b0);
        serve(1'b1, 16'd101, 2, 1, 1, 1'b0, 1'b0);
        serve(1'b1, 16'd102, 2, 1, 1, 1'b0, 1'b0);
        serve(1'b1, 16'd104, 2, 1, 1, 1'b0, 1'b0);
        serve(1'b1, 16'hFFFF, 2, 1, 1, 1'b0, 1'b0);
        serve(1'b1, 16'hFFFF, 2, 1, 1, 1'b0, 1'b0);
        serve(1'b1, 16'hFFFF, 2, 1, 1, 1'b0, 1'b0);
        serve(1'b1, 16'hFFFE, 2, 1, 1, 1'b0, 1'b0);

        // Randomised readings, formats and handshake timing
        for (int n = 0; n < 24; n++) begin
            logic [15:0] r;
            r = 16'($urandom);
            serve(1'($urandom_range(0, 1)), r, $urandom_range(1, 5),
                  $urandom_range(1, 10), $urandom_range(1, 5), 1'b0, 1'b0);
        end

        // Slow responder (~30 cycles) spanning more than one period
        for (int n = 0; n < 3; n++) serve(1'b1, 16'(16'h0100 + n), 3, 24, 2, 1'b0, 1'b0);

        // Timeout, retry succeeds, then saturate the error counter
        do_timeout();
        serve(1'b1, 16'h0A00, 3, 2, 1, 1'b0, 1'b0);
        for (int n = 0; n < 258; n++) do_timeout();
        serve(1'b1, 16'h0B00, 3, 2, 1, 1'b0, 1'b0);

        // Reset while waiting for data
        serve(1'b1, 16'h0C00, 3, 4, 1, 1'b0, 1'b1);
        serve(1'b1, 16'h0D00, 3, 2, 1, 1'b0, 1'b0);

        // clear_stats landing in the processing cycle
        do_timeout();
        do_timeout();
        serve(1'b1, 16'h0E00, 3, 2, 1, 1'b0, 1'b0);
        serve(1'b0, 16'h1234, 3, 2, 1, 1'b1, 1'b0);
        serve(1'b1, 16'hF000, 3, 2, 1, 1'b0, 1'b0);

        enable = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        check("pending_samples", exp_q.size(), 0);
        check("pending_timeouts", to_exp_q.size(), 0);
        check("one_request_per_transaction", rises, requests);
        check("idle_after_disable", int'(update), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tmp2_sampler.md
# tmp2_sampler

Periodic acquisition and post-processing stage that sits directly around the Pmod TMP2 interface (`tmp2`). It raises that block's `update` request on a programmable period and waits for the interface's `busy`/`valid_o` handshake. It captures the raw 16-bit reading and normalises it to signed 1/128 °C, independent of the configured resolution. It then publishes the current sample, a block average over 2^AVG_LOG2 samples, running min/max, and a timeout error counter for display or alarm logic.

## Interface
- `PERIOD_CYCLES`, 100_000_000: `clk` cycles between sample requests; minimum 2.
- `TIMEOUT_CYCLES`, 10_000_000: `clk` cycles allowed from request to valid data.
- `AVG_LOG2`, 3: log2 of the number of samples per average block, range 0–6.
- `clk` in 1: system clock, the same as the `tmp2` `clk`.
- `rst` in 1: reset, asynchronous, active-high.
- `enable` in 1: allow periodic requests.
- `resolution` in 1: 0 = 13-bit format, 1 = 16-bit format. Must match the `tmp2` `resolution` input.
- `clear_stats` in 1: single-cycle pulse; clears min/max, the accumulator and the error counter.
- `update` out 1: request to `tmp2.update`.
- `busy` in 1: from `tmp2.busy`.
- `valid_i` in 1: from `tmp2.valid_o`; level signal that rises after a read completes.
- `temperature_i` in 16: from `tmp2.temperature_o`; raw register value.
- `sample_o` out 16: signed, 1/128 °C.
- `sample_valid` out 1: single-cycle strobe on each new `sample_o`.
- `average_o` out 16: signed, 1/128 °C.
- `average_valid` out 1: single-cycle strobe on each new `average_o`.
- `min_o` out 16: signed running minimum.
- `max_o` out 16: signed running maximum.
- `stats_valid` out 1: high once min/max hold at least one sample.
- `timeout_o` out 1: single-cycle strobe when a request times out.
- `err_count` out 8: timeout count, saturating at 255.

## Operation
- **Reset value of every output:** 0.
- **Period counter:**
  - Loads 0 at reset.
  - When it reads 0 with `enable`=1 it generates a tick and reloads PERIOD_CYCLES-1; otherwise it decrements.
  - The first tick therefore fires one cycle after `enable` rises following reset.
  - A tick that arrives while the FSM is not in IDLE is dropped; it is not queued.
- **FSM:**
  - **IDLE:** on a tick, go to REQ and clear the timeout counter.
  - **REQ:** `update`=1. Stay until `busy`=1, then go to WAIT with `update`=0.
  - **WAIT:** wait for the `valid_i` rising edge, detected as current `valid_i` & ~registered `valid_i`. On the edge, latch `temperature_i` and go to PROC.
  - **PROC:** one cycle; apply conversion and statistics, then return to IDLE.
  - **Timeout:** in REQ or WAIT, if the counter reaches TIMEOUT_CYCLES-1, drop `update`, pulse `timeout_o`, increment `err_count` (saturating), and return to IDLE.
  - If `busy` rises because of a non-read transaction (config, one-shot) and no valid edge follows, the request ends by timeout; the next tick retries.
- **Conversion:**
  - `resolution`=1: sample = `temperature_i`.
  - `resolution`=0: sample = {`temperature_i`[15:3], 3'b000}; the low 3 status bits are discarded.
  - The result is signed 1/128 °C in both cases.
- **Min/max:**
  - Signed compare.
  - The first sample after reset or `clear_stats` loads both min and max and sets `stats_valid`.
- **Average:**
  - The accumulator is signed, 16+AVG_LOG2 bits wide, and sums 2^AVG_LOG2 samples.
  - On the last sample of a block, `average_o` = (acc + sample) >>> AVG_LOG2 (arithmetic shift, truncation toward −∞). The accumulator and sample count then clear.
- **`clear_stats`:**
  - Clears acc, count, `stats_valid`, min, max and `err_count`. It does not affect the FSM or `sample_o`.
  - If it coincides with PROC, the clear wins and the current sample is not folded into the statistics. `sample_o` and `sample_valid` still update.
- **`enable` deasserted:** stops new ticks only; an in-flight request completes or times out.

## Timing
- `update` rises the cycle after the tick is registered (IDLE→REQ).
- `update` falls the cycle after `busy`=1 is sampled.
- Valid edge at cycle N: `temperature_i` is latched at N; `sample_o`, `sample_valid`, min/max and `average_o`/`average_valid` update at N+1. Latency is 2 cycles from the `valid_i` edge.
- `timeout_o` fires exactly TIMEOUT_CYCLES cycles after entry to REQ.
- `rst` mid-operation: all state returns to reset values immediately and `update` drops asynchronously.

## Test plan
- **Single read, 16-bit format:** `resolution`=1; the bench model raises `busy` 3 cycles after `update`, then `valid_i` with `temperature_i`=16'h0C80. Required: `sample_o`=16'h0C80 (25.0 °C), one `sample_valid` strobe, min=max=16'h0C80, `stats_valid`=1.
- **13-bit format with negative value:** `resolution`=0, `temperature_i`=16'hFF07 (flags set). Required: `sample_o`=16'hFF00 (−2.0 °C), min updated to 16'hFF00.
- **Average:** AVG_LOG2=2; samples 100, 101, 102, 104. Required: a single `average_valid` strobe after the 4th sample, with `average_o`=101. Samples −1, −1, −1, −2 give −2.
- **Timeout:** TIMEOUT_CYCLES=50 and `busy` never rises. Required: `update` high for 50 cycles, then `timeout_o` pulse, `err_count`=1, and a retry on the next tick. Sustained timeouts saturate `err_count` at 255.
- **Dropped tick:** PERIOD_CYCLES=20 and the responder takes 30 cycles. Required: exactly one request per completed transaction, and no `update` while in WAIT.
- **Reset and clear mid-operation:** assert `rst` in WAIT; all outputs return to 0 and `update`=0. Separately, pulse `clear_stats` during PROC; `sample_o` updates, `stats_valid`=0, `err_count`=0.
